// File: rtl/gravity_rategen.sv
// gravity_rategen: level-tracking fall/tempo tick generator with soft drop, pause, restart and line-driven level progression.
module gravity_rategen #(
  parameter int CNT_W           = 26,
  parameter int BASE_DIV        = 50000000,
  parameter int STEP_DIV        = 5000000,
  parameter int MIN_DIV         = 5000000,
  parameter int DROP_DIV        = 5000000,
  parameter int MAX_LEVEL       = 9,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic [3:0]  start_level,
  input  logic        restart,
  input  logic        pause,
  input  logic        drop,
  input  logic        line_clr,
  input  logic [2:0]  lines,
  output logic        en,
  output logic [3:0]  level,
  output logic        level_up,
  output logic [15:0] lines_total
);
  localparam int W  = CNT_W + 4;
  localparam int AW = $clog2(LINES_PER_LEVEL + 5);
  logic [CNT_W-1:0] cntr_q, cntr_d, limit;
  logic [3:0] level_q, level_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [15:0] tot_q, tot_d;
  logic [16:0] tot_sum;
  logic up_q, up_d, drop_q, valid, wrap;
  logic signed [W-1:0] grav;
  logic [W-1:0] per;
  // Wide signed arithmetic so a deep level can go negative and still clamp to the floor.
  always_comb begin
    grav = $signed(W'(BASE_DIV)) - $signed(W'(STEP_DIV)) * $signed(W'(level_q - 4'd1));
    per = drop_q ? W'(DROP_DIV) : (grav < $signed(W'(MIN_DIV))) ? W'(MIN_DIV) : W'(grav);
    limit = CNT_W'(per - W'(1));
  end
  assign en = (cntr_q >= limit) && !pause && !rst;
  assign valid = line_clr && lines != 3'd0 && lines <= 3'd4;
  assign sum = acc_q + AW'(lines);
  assign wrap = sum >= AW'(LINES_PER_LEVEL);
  assign tot_sum = {1'b0, tot_q} + 17'(lines);
  always_comb begin
    cntr_d = (new_game || restart) ? '0 : pause ? cntr_q : (cntr_q >= limit) ? '0 : cntr_q + CNT_W'(1);
    level_d = level_q;
    acc_d = acc_q;
    tot_d = tot_q;
    up_d = 1'b0;
    if (new_game) begin
      level_d = (start_level == 4'd0) ? 4'd1 : (start_level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : start_level;
      acc_d = '0;
      tot_d = '0;
    end else if (valid) begin
      tot_d = tot_sum[16] ? 16'hffff : tot_sum[15:0];
      acc_d = wrap ? sum - AW'(LINES_PER_LEVEL) : sum;
      up_d = wrap && level_q < 4'(MAX_LEVEL);
      level_d = up_d ? level_q + 4'd1 : level_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr_q <= '0;
      level_q <= 4'd1;
      acc_q <= '0;
      tot_q <= '0;
      up_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cntr_q <= cntr_d;
      level_q <= level_d;
      acc_q <= acc_d;
      tot_q <= tot_d;
      up_q <= up_d;
      drop_q <= drop;
    end
  end
  assign level = level_q;
  assign level_up = up_q;
  assign lines_total = tot_q;
endmodule

// File: tb/tb_gravity_rategen.sv
// tb_gravity_rategen: randomized and directed checks of gravity_rategen against an arithmetic reference model.
module tb_gravity_rategen;
  localparam int BASE = 20, STEP = 2, MINP = 6, DROPP = 3, MAXL = 9, LPL = 10;
  logic clk = 0, rst = 1, new_game = 0, restart = 0, pause = 0, drop = 0, line_clr = 0;
  logic [3:0] start_level = 0;
  logic [2:0] lines = 0;
  logic en, level_up;
  logic [3:0] level;
  logic [15:0] lines_total;
  int checks = 0, errors = 0;
  int m_el, m_start, m_total, m_up, m_drop, m_per, m_ol, n;

  gravity_rategen #(.CNT_W(8), .BASE_DIV(BASE), .STEP_DIV(STEP), .MIN_DIV(MINP),
    .DROP_DIV(DROPP), .MAX_LEVEL(MAXL), .LINES_PER_LEVEL(LPL)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .start_level(start_level), .restart(restart),
    .pause(pause), .drop(drop), .line_clr(line_clr), .lines(lines), .en(en), .level(level),
    .level_up(level_up), .lines_total(lines_total));

  always #5 clk = ~clk;

  // Level follows from the starting level plus whole multiples of LPL cleared lines.
  function automatic int mlvl();
    int l = m_start + m_total / LPL;
    return l > MAXL ? MAXL : l;
  endfunction
  function automatic int mper();
    int g = BASE - (mlvl() - 1) * STEP;
    return m_drop != 0 ? DROPP : (g < MINP ? MINP : g);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_el = 0; m_start = 1; m_total = 0; m_up = 0; m_drop = 0;
    end else begin
      m_per = mper();
      if (new_game || restart) m_el = 0;
      else if (!pause) m_el = (m_el >= m_per - 1) ? 0 : m_el + 1;
      m_drop = int'(drop);
      m_up = 0;
      if (new_game) begin
        m_start = start_level == 0 ? 1 : (start_level > MAXL ? MAXL : int'(start_level));
        m_total = 0;
      end else if (line_clr && lines >= 1 && lines <= 4) begin
        m_ol = mlvl();
        m_total += int'(lines);
        m_up = int'(mlvl() > m_ol);
      end
    end
  end

  always @(negedge clk) begin
    chk("en", int'(en), int'((m_el >= mper() - 1) && !pause && !rst));
    chk("level", int'(level), mlvl());
    chk("level_up", int'(level_up), m_up);
    chk("lines_total", int'(lines_total), m_total > 65535 ? 65535 : m_total);
  end

  task automatic count_to_en(output int c);
    for (c = 0; c < 500; c++) begin
      @(negedge clk);
      if (en) break;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_level", int'(level), 1);
    chk("reset_total", int'(lines_total), 0);
    count_to_en(n); chk("first_en", n, 19);
    count_to_en(n); chk("period20", n, 19);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 drop = 1;
    count_to_en(n); chk("drop_next", n, 1);
    count_to_en(n); chk("drop_period", n, 2);
    drop = 0;
    count_to_en(n); chk("drop_release", n, 19);
    step(); line_clr = 1; lines = 4;
    step(); lines = 4;
    step(); lines = 2;
    step(); line_clr = 0;
    @(negedge clk);
    chk("lvl_up_pulse", int'(level_up), 1);
    chk("lvl2", int'(level), 2);
    chk("total10", int'(lines_total), 10);
    step(); restart = 1;
    step(); restart = 0;
    count_to_en(n); chk("period18", n, 17);
    step(); new_game = 1; start_level = 9;
    step(); new_game = 0;
    count_to_en(n); chk("period6", n, 5);
    chk("lvl9", int'(level), 9);
    for (int i = 0; i < 10; i++) begin
      step(); line_clr = 1; lines = 4;
      @(negedge clk); chk("no_up_at_max", int'(level_up), 0);
    end
    step(); line_clr = 0;
    @(negedge clk);
    chk("max_up", int'(level_up), 0);
    chk("max_lvl", int'(level), 9);
    chk("total40", int'(lines_total), 40);
    step(); new_game = 1; start_level = 0;
    step(); new_game = 0;
    @(negedge clk);
    chk("start0", int'(level), 1);
    chk("ng_total", int'(lines_total), 0);
    repeat (7) @(posedge clk);
    #1 pause = 1;
    repeat (50) begin
      @(negedge clk); chk("paused_en", int'(en), 0);
    end
    step(); pause = 0;
    count_to_en(n); chk("resume", n, 12);
    step(); restart = 1;
    step(); restart = 0;
    count_to_en(n); chk("restart", n, 19);
    step(); new_game = 1; start_level = 5;
    step(); new_game = 0; line_clr = 1; lines = 3;
    step(); line_clr = 0;
    @(negedge clk);
    chk("lvl5", int'(level), 5);
    chk("total3", int'(lines_total), 3);
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_lvl", int'(level), 1);
    chk("async_total", int'(lines_total), 0);
    chk("async_en", int'(en), 0);
    step(); rst = 0;
    count_to_en(n); chk("post_rst_en", n, 19);
    for (int i = 0; i < 4000; i++) begin
      step();
      new_game = ($urandom % 200) == 0;
      start_level = 4'($urandom_range(0, 15));
      restart = ($urandom % 30) == 0;
      if ($urandom % 20 == 0) pause = !pause;
      if ($urandom % 15 == 0) drop = !drop;
      line_clr = ($urandom % 4) == 0;
      lines = 3'($urandom_range(0, 7));
      if ($urandom % 700 == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
    end
    step(); new_game = 1; start_level = 1; restart = 0; pause = 0; drop = 0; line_clr = 0;
    step(); new_game = 0; line_clr = 1; lines = 4;
    repeat (16400) @(posedge clk);
    #1 line_clr = 0;
    @(negedge clk);
    chk("sat_total", int'(lines_total), 65535);
    chk("sat_level", int'(level), 9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
